wptr_full_ctrl: RTL and testbench
=================================

# wptr_full_ctrl

Write-side pointer and full-flag controller for the asynchronous FIFO, in the write clock domain. It is the counterpart that feeds the read-side empty logic. It accepts write requests and drives the dual-port memory write address and enable. It publishes a Gray-coded write pointer for synchronization into the read domain. It derives full, almost-full, fill level and overflow status from the read pointer after that pointer has been synchronized into the write domain.

## Interface
Parameters:
- ASIZE, 4, memory address width; FIFO depth = 2**ASIZE
- AF_THRESH, 12, walmost_full asserts when wlevel >= AF_THRESH; legal range 1..2**ASIZE

Ports:
- wclk  input  1  write-domain clock; all state on rising edge
- wrst  input  1  asynchronous, active-high reset
- winc  input  1  write request
- wq2_rptr  input  ASIZE+1  read pointer (Gray) already two-flop synchronized into wclk
- wovf_clr  input  1  clears woverflow and wovf_cnt
- wen  output  1  memory write enable, combinational = winc & ~wfull
- waddr  output  ASIZE  memory write address = wbin[ASIZE-1:0]
- wptr  output  ASIZE+1  registered Gray write pointer
- wfull  output  1  registered full flag
- walmost_full  output  1  registered almost-full flag
- wlevel  output  ASIZE+1  registered fill level, range 0..2**ASIZE
- woverflow  output  1  sticky flag: a write was attempted while full
- wovf_cnt  output  8  count of rejected writes, saturates at 255

## Operation
- State:
  - wbin: ASIZE+1-bit binary counter
  - wptr: Gray register
  - flag, level and overflow registers
- Pointer update:
  - wbinnext = wbin + wen (modulo 2**(ASIZE+1))
  - wgraynext = (wbinnext >> 1) ^ wbinnext
  - Each edge: wbin <= wbinnext and wptr <= wgraynext
- Read pointer conversion: rbin_s = Gray-to-binary of wq2_rptr, bitwise prefix XOR from the MSB down. This is purely combinational.
- Full flag:
  - wfull_val = (wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]})
  - wfull <= wfull_val
- Level:
  - wlevel <= wbinnext - rbin_s, modulo 2**(ASIZE+1)
  - The level is conservative because the read pointer is stale by synchronizer latency, so it never under-reports.
- Almost full: walmost_full <= ((wbinnext - rbin_s) >= AF_THRESH).
- Overflow:
  - reject = winc & wfull
  - If reject, woverflow <= 1 and wovf_cnt increments, saturating at 255.
  - Else if wovf_clr, both clear to 0.
  - When reject and wovf_clr occur on the same edge, set wins: woverflow = 1 and wovf_cnt = previous count + 1, saturating.
- A rejected write must not change wbin, wptr, waddr or memory contents.
- Wrap-around:
  - wbin rolls from 2**(ASIZE+1)-1 to 0 with no special case.
  - Gray adjacency across the wrap must hold: exactly one bit of wptr changes per accepted write.

## Timing
- Reset values while wrst is high, applied immediately and asynchronously:
  - wbin = 0, wptr = 0, wfull = 0, walmost_full = 0
  - wlevel = 0, woverflow = 0, wovf_cnt = 0
  - As a consequence, waddr = 0 and wen = winc.
- Reset may assert mid-stream. All registers return to reset values regardless of winc. The first edge after deassertion processes winc normally.
- Write latency:
  - An accepted write at edge N is stored at waddr(N).
  - waddr, wptr and wlevel reflect the write after edge N.
- wfull asserts on the same edge that accepts the 2**ASIZE-th outstanding write. No extra write can slip in after that edge.
- wfull deasserts on the first edge at which the updated wq2_rptr no longer matches. Read-side pops become visible here only 2 wclk cycles after the read domain publishes them, because they pass through the external synchronizer.
- wen is combinational from winc and registered wfull. It carries no register stage.
- Simultaneous winc and a read-pointer advance on the same edge: both are reflected in the same wlevel and wfull update.

## Test plan
Run with ASIZE=4 and AF_THRESH=12 unless stated otherwise.

- Fill: hold wq2_rptr=0 and assert winc for 16 cycles.
  - After the 12th accepted write: walmost_full=1.
  - After the 16th accepted write: wfull=1, wptr=5'b11000, waddr=0, wlevel=16.
  - wen=0 on the 17th cycle.
- Overflow: while full, hold winc for 300 cycles.
  - wbin and wptr do not change.
  - woverflow=1 and wovf_cnt=255.
  - Pulse wovf_clr with winc=0: both return to 0.
  - Pulse wovf_clr with winc=1 while still full: woverflow=1 and wovf_cnt=1.
- Drain visibility: from full, set wq2_rptr=5'b00110 (binary 4).
  - Next edge: wfull=0, wlevel=12, walmost_full=1.
  - Set wq2_rptr=5'b00111 (binary 5): wlevel=11, walmost_full=0.
- Wrap: write 40 words while wq2_rptr tracks wptr with a 2-cycle lag.
  - wfull never asserts.
  - wbin wraps from 31 to 0.
  - Every wptr transition changes exactly one bit.
- Simultaneous events: at level 15, apply winc=1 on the same edge that wq2_rptr advances by 1.
  - wlevel stays 15 and wfull=0.
- Reset mid-operation: at level 9 with woverflow=1, assert wrst between clock edges.
  - All outputs go to their reset values immediately.
  - After release, the first winc writes waddr=0.

Source files
------------

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/level/overflow controller for an asynchronous FIFO.
// Publishes a Gray write pointer and derives status from the synchronized Gray read pointer.
module wptr_full_ctrl #(
  parameter int ASIZE     = 4,
  parameter int AF_THRESH = 12
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic             wovf_clr,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow,
  output logic [7:0]       wovf_cnt
);

  localparam logic [ASIZE:0] AF_LVL = (ASIZE+1)'(AF_THRESH);

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] rbin_s;
  logic [ASIZE:0] wbin_next;
  logic [ASIZE:0] wgray_next;
  logic [ASIZE:0] level_next;
  logic           full_val;
  logic           reject;

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign wen    = winc & ~wfull;
  assign waddr  = wbin[ASIZE-1:0];
  assign reject = winc & wfull;

  // Full when the next write pointer equals the read pointer with the two MSBs inverted
  always_comb begin
    rbin_s     = gray2bin(wq2_rptr);
    wbin_next  = wbin + (ASIZE+1)'(wen);
    wgray_next = (wbin_next >> 1) ^ wbin_next;
    level_next = wbin_next - rbin_s;
    full_val   = (wgray_next == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= full_val;
      walmost_full <= (level_next >= AF_LVL);
      wlevel       <= level_next;
    end
  end

  // A reject on the same edge as a clear takes priority
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      woverflow <= 1'b0;
      wovf_cnt  <= 8'd0;
    end else if (reject) begin
      woverflow <= 1'b1;
      wovf_cnt  <= sat_inc(wovf_cnt);
    end else if (wovf_clr) begin
      woverflow <= 1'b0;
      wovf_cnt  <= 8'd0;
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Randomized and directed bench for wptr_full_ctrl against an occupancy-count reference model.
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wovf_clr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;
  logic [7:0] wovf_cnt;

  wptr_full_ctrl #(.ASIZE(4), .AF_THRESH(12)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr), .wovf_clr(wovf_clr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow), .wovf_cnt(wovf_cnt)
  );

  always #5 wclk = ~wclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: total accepted writes and total reads as plain integers
  int m_wr, m_rd, m_cnt;
  bit m_full, m_ovf;

  function automatic int gray(input int n);
    return (n >> 1) ^ n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_cnt = 0; m_full = 0; m_ovf = 0;
  endtask

  task automatic chk_regs();
    int lvl;
    lvl = m_wr - m_rd;
    chk("wptr", wptr, gray(m_wr % 32));
    chk("waddr", waddr, m_wr % 16);
    chk("wlevel", wlevel, lvl);
    chk("wfull", wfull, m_full);
    chk("walmost_full", walmost_full, lvl >= 12);
    chk("woverflow", woverflow, m_ovf);
    chk("wovf_cnt", wovf_cnt, m_cnt);
  endtask

  // One write-clock cycle; m_rd must already hold the read count visible at this edge
  task automatic step(input logic inc, input logic clr, input bit one_bit = 0);
    logic [4:0] prev;
    bit acc;
    winc = inc; wovf_clr = clr; wq2_rptr = 5'(gray(m_rd % 32));
    #1;
    chk("wen", wen, inc & ~m_full);
    prev = wptr;
    @(posedge wclk); #1;
    acc = inc && !m_full;
    if (acc) m_wr++;
    if (inc && m_full) begin
      m_ovf = 1;
      if (m_cnt < 255) m_cnt++;
    end else if (clr) begin
      m_ovf = 0; m_cnt = 0;
    end
    m_full = ((m_wr - m_rd) == 16);
    chk_regs();
    if (one_bit && acc) chk("gray_step", $countones(prev ^ wptr), 1);
  endtask

  initial begin
    int hist[$];
    int adv, room;
    model_reset();
    winc = 1'b1; wovf_clr = 1'b0; wq2_rptr = '0; wrst = 1'b1;
    #2;
    chk("rst_wen", wen, 1);
    chk_regs();
    winc = 1'b0;
    @(negedge wclk); @(negedge wclk); wrst = 1'b0;
    @(posedge wclk); #1;

    // Fill with read pointer held at zero
    for (int i = 1; i <= 16; i++) begin
      step(1, 0);
      if (i == 11) chk("af_11", walmost_full, 0);
      if (i == 12) chk("af_12", walmost_full, 1);
    end
    chk("fill_full", wfull, 1);
    chk("fill_wptr", wptr, 5'b11000);
    chk("fill_waddr", waddr, 0);
    chk("fill_level", wlevel, 16);
    winc = 1'b1; #1;
    chk("wen_17", wen, 0);

    // Overflow saturation and clearing
    for (int i = 0; i < 300; i++) step(1, 0);
    chk("ovf_wptr", wptr, 5'b11000);
    chk("ovf_flag", woverflow, 1);
    chk("ovf_cnt", wovf_cnt, 255);
    step(0, 1);
    chk("clr_cnt", wovf_cnt, 0);
    step(1, 1);
    chk("clr_set_cnt", wovf_cnt, 1);
    chk("clr_set_flag", woverflow, 1);

    // Drain visibility
    m_rd = 4;
    step(0, 0);
    chk("drain_full", wfull, 0);
    chk("drain_lvl12", wlevel, 12);
    chk("drain_af12", walmost_full, 1);
    m_rd = 5;
    step(0, 0);
    chk("drain_lvl11", wlevel, 11);
    chk("drain_af11", walmost_full, 0);

    // Write and read on the same edge at level 15
    for (int i = 0; i < 4; i++) step(1, 0);
    chk("pre_sim_lvl", wlevel, 15);
    m_rd = 6;
    step(1, 0);
    chk("sim_lvl", wlevel, 15);
    chk("sim_full", wfull, 0);

    // Wrap with the read pointer lagging two cycles behind
    m_rd = m_wr;
    step(0, 0);
    hist = {m_wr, m_wr};
    for (int i = 0; i < 40; i++) begin
      m_rd = hist.pop_front();
      step(1, 0, 1);
      chk("wrap_nofull", wfull, 0);
      hist.push_back(m_wr);
    end

    // Reset mid-operation at level 9 with overflow set
    m_rd = m_wr;
    step(0, 0);
    for (int i = 0; i < 17; i++) step(1, 0);
    m_rd = m_rd + 7;
    step(0, 0);
    chk("pre_rst_lvl", wlevel, 9);
    chk("pre_rst_ovf", woverflow, 1);
    #1; wrst = 1'b1; winc = 1'b0; wq2_rptr = '0;
    #1;
    model_reset();
    chk_regs();
    @(negedge wclk); wrst = 1'b0;
    @(posedge wclk); #1;
    winc = 1'b1; #1;
    chk("post_rst_waddr", waddr, 0);
    chk("post_rst_wen", wen, 1);
    step(1, 0);

    // Randomized traffic with alternating read pressure
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 100; i++) begin
        room = m_wr - m_rd;
        adv = 0;
        if ($urandom_range(99) < ((seg % 2) ? 60 : 10)) adv = $urandom_range(1, 2);
        if (adv > room) adv = room;
        m_rd = m_rd + adv;
        step(logic'($urandom_range(99) < 70), logic'($urandom_range(99) < 3), 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
